core_block_sequencer: RTL and testbench

Per-compute-unit block sequencer. It is the receiving end of the block dispatcher's start/done handshake: it latches an assigned block ID and splits the block into warps of `WARP_SIZE` threads. It issues each warp, with a global base thread ID and a lane-valid mask, to the core's warp pipeline, and waits for each warp to retire. When every warp of the block has retired, it raises `done` until the dispatcher withdraws `start`.

---
 rtl/core_block_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_core_block_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_block_sequencer.sv
// core_block_sequencer
// Receives a block assignment from the block dispatcher through a start/done
// handshake. The block is split into warps of WARP_SIZE threads, and the warps
// are issued one at a time to the core's warp pipeline. Each warp must retire
// before the next one is issued.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           dispatcher start, high while a block is assigned
//   block_id        signed block ID (-1 = invalid), valid while start=1
//   num_threads     kernel thread count (static)
//   block_dim       threads per block (static, nonzero)
//   done            block finished, held until start falls
//   busy            high in SETUP, ISSUE and WAIT
//   cur_block_id    latched block ID, -1 when idle
//   bad_block       last accepted start carried a negative block_id
//   warp_valid      warp descriptor valid
//   warp_ready      pipeline accepts the descriptor
//   warp_base_tid   global thread ID of lane 0
//   warp_mask       lane-valid mask
//   warp_id         warp index within the block
//   warp_retire     one-cycle pulse, the issued warp has completed
module core_block_sequencer #(
  parameter int WARP_SIZE = 8,
  parameter int WARP_ID_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [31:0]          block_id,
  input  logic [31:0]          num_threads,
  input  logic [31:0]          block_dim,
  output logic                 done,
  output logic                 busy,
  output logic [31:0]          cur_block_id,
  output logic                 bad_block,
  output logic                 warp_valid,
  input  logic                 warp_ready,
  output logic [31:0]          warp_base_tid,
  output logic [WARP_SIZE-1:0] warp_mask,
  output logic [WARP_ID_W-1:0] warp_id,
  input  logic                 warp_retire
);

  localparam int LANE_SH = $clog2(WARP_SIZE);

  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, DONE} state_t;

  state_t               state, state_nx;
  logic [31:0]          cur_nx;
  logic                 bad_nx;
  logic [31:0]          base, base_nx;
  logic [31:0]          nthr, nthr_nx;
  logic [31:0]          last_warp, last_nx;
  logic [31:0]          warp_off, off_nx;
  logic [WARP_ID_W-1:0] id_nx;
  logic [31:0]          tid_nx;
  logic [WARP_SIZE-1:0] mask_nx;

  logic [31:0]          setup_base;
  logic [31:0]          setup_rem;
  logic [31:0]          setup_nthr;
  logic [32:0]          setup_nwarps;
  logic [31:0]          next_off;

  // Lane l is real when (offset + l) < count; 33-bit sum avoids wrap-around.
  function automatic logic [WARP_SIZE-1:0] lane_mask(input logic [31:0] offset,
                                                     input logic [31:0] count);
    logic [WARP_SIZE-1:0] m;
    m = '0;
    for (int l = 0; l < WARP_SIZE; l++) begin
      m[l] = (({1'b0, offset} + 33'(l)) < {1'b0, count});
    end
    return m;
  endfunction

  // Block geometry computed from the latched block ID during SETUP.
  always_comb begin
    setup_base = cur_block_id * block_dim;
    setup_rem  = num_threads - setup_base;
    if (setup_base >= num_threads) begin
      setup_nthr = 32'd0;
    end else if (setup_rem < block_dim) begin
      setup_nthr = setup_rem;
    end else begin
      setup_nthr = block_dim;
    end
    setup_nwarps = ({1'b0, setup_nthr} + 33'(WARP_SIZE - 1)) >> LANE_SH;
    next_off     = warp_off + 32'(WARP_SIZE);
  end

  // Next-state and next-descriptor logic; an abort (start low) wins over
  // handshake and retire in every busy state.
  always_comb begin
    state_nx = state;
    cur_nx   = cur_block_id;
    bad_nx   = bad_block;
    base_nx  = base;
    nthr_nx  = nthr;
    last_nx  = last_warp;
    off_nx   = warp_off;
    id_nx    = warp_id;
    tid_nx   = warp_base_tid;
    mask_nx  = warp_mask;
    case (state)
      IDLE: begin
        if (start) begin
          cur_nx   = block_id;
          bad_nx   = block_id[31];
          state_nx = block_id[31] ? DONE : SETUP;
        end else begin
          state_nx = IDLE;
        end
      end
      SETUP: begin
        if (!start) begin
          state_nx = IDLE;
          cur_nx   = 32'hFFFF_FFFF;
        end else begin
          base_nx  = setup_base;
          nthr_nx  = setup_nthr;
          last_nx  = 32'(setup_nwarps - 33'd1);
          off_nx   = 32'd0;
          id_nx    = '0;
          tid_nx   = setup_base;
          mask_nx  = lane_mask(32'd0, setup_nthr);
          state_nx = (setup_nthr == 32'd0) ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (!start) begin
          state_nx = IDLE;
          cur_nx   = 32'hFFFF_FFFF;
        end else if (warp_ready) begin
          state_nx = WAIT;
        end else begin
          state_nx = ISSUE;
        end
      end
      WAIT: begin
        if (!start) begin
          state_nx = IDLE;
          cur_nx   = 32'hFFFF_FFFF;
        end else if (warp_retire) begin
          if (32'(warp_id) == last_warp) begin
            state_nx = DONE;
          end else begin
            id_nx    = warp_id + 1'b1;
            off_nx   = next_off;
            tid_nx   = warp_base_tid + 32'(WARP_SIZE);
            mask_nx  = lane_mask(next_off, nthr);
            state_nx = ISSUE;
          end
        end else begin
          state_nx = WAIT;
        end
      end
      DONE: begin
        if (!start) begin
          state_nx = IDLE;
          cur_nx   = 32'hFFFF_FFFF;
        end else begin
          state_nx = DONE;
        end
      end
      default: begin
        state_nx = IDLE;
        cur_nx   = 32'hFFFF_FFFF;
      end
    endcase
  end

  // State, block context and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cur_block_id  <= 32'hFFFF_FFFF;
      bad_block     <= 1'b0;
      base          <= 32'd0;
      nthr          <= 32'd0;
      last_warp     <= 32'd0;
      warp_off      <= 32'd0;
      warp_id       <= '0;
      warp_base_tid <= 32'd0;
      warp_mask     <= '0;
      warp_valid    <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_nx;
      cur_block_id  <= cur_nx;
      bad_block     <= bad_nx;
      base          <= base_nx;
      nthr          <= nthr_nx;
      last_warp     <= last_nx;
      warp_off      <= off_nx;
      warp_id       <= id_nx;
      warp_base_tid <= tid_nx;
      warp_mask     <= mask_nx;
      warp_valid    <= (state_nx == ISSUE);
      busy          <= (state_nx == SETUP) || (state_nx == ISSUE) || (state_nx == WAIT);
      done          <= (state_nx == DONE);
    end
  end

endmodule

// File: tb/tb_core_block_sequencer.sv
// Directed bench for core_block_sequencer (WARP_SIZE=4, block_dim=8,
// num_threads=19). Expected warp descriptors and done episodes are queued by
// the stimulus; monitors on the falling edge pop and compare them.
module tb_core_block_sequencer;

  localparam int WS = 4;
  localparam int IDW = 16;

  typedef struct packed {
    logic [31:0]    tid;
    logic [WS-1:0]  mask;
    logic [IDW-1:0] id;
  } desc_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [31:0]    block_id;
  logic [31:0]    num_threads;
  logic [31:0]    block_dim;
  logic           done;
  logic           busy;
  logic [31:0]    cur_block_id;
  logic           bad_block;
  logic           warp_valid;
  logic           warp_ready;
  logic [31:0]    warp_base_tid;
  logic [WS-1:0]  warp_mask;
  logic [IDW-1:0] warp_id;
  logic           warp_retire;

  desc_t       warp_q[$];
  logic [31:0] done_q[$];
  int          checks = 0;
  int          passed = 0;
  logic        prev_done = 1'b0;

  core_block_sequencer #(.WARP_SIZE(WS), .WARP_ID_W(IDW)) dut (
    .clk(clk), .rst(rst), .start(start), .block_id(block_id),
    .num_threads(num_threads), .block_dim(block_dim), .done(done),
    .busy(busy), .cur_block_id(cur_block_id), .bad_block(bad_block),
    .warp_valid(warp_valid), .warp_ready(warp_ready),
    .warp_base_tid(warp_base_tid), .warp_mask(warp_mask),
    .warp_id(warp_id), .warp_retire(warp_retire)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block(input logic [31:0] id);
    block_id = id;
    start    = 1'b1;
    tick();
  endtask

  task automatic end_block();
    start = 1'b0;
    tick();
    check("done_fall", {31'd0, done}, 32'd1 - 32'd1);
    check("cur_idle", cur_block_id, 32'hFFFF_FFFF);
  endtask

  // Accept the presented warp, idle one cycle in WAIT, then retire it.
  task automatic do_warp();
    check("valid_before_accept", {31'd0, warp_valid}, 32'd1);
    warp_ready = 1'b1;
    tick();
    warp_ready = 1'b0;
    check("valid_in_wait", {31'd0, warp_valid}, 32'd0);
    tick();
    warp_retire = 1'b1;
    tick();
    warp_retire = 1'b0;
  endtask

  // Warp scoreboard: a descriptor is consumed when valid and ready coincide.
  always @(negedge clk) begin
    if (!rst && warp_valid && warp_ready) begin
      if (warp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_warp: tid %0h mask %0h id %0h", warp_base_tid, warp_mask, warp_id);
      end else begin
        desc_t e;
        e = warp_q.pop_front();
        check("warp_tid", warp_base_tid, e.tid);
        check("warp_mask", {28'd0, warp_mask}, {28'd0, e.mask});
        check("warp_id", {16'd0, warp_id}, {16'd0, e.id});
      end
    end
  end

  // Done scoreboard: each rising edge of done is one episode for one block.
  always @(negedge clk) begin
    if (done && !prev_done) begin
      if (done_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_done: cur_block_id %0h", cur_block_id);
      end else begin
        check("done_block", cur_block_id, done_q.pop_front());
      end
    end
    prev_done <= done;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; block_id = 32'd0;
    num_threads = 32'd19; block_dim = 32'd8;
    warp_ready = 1'b0; warp_retire = 1'b0;
    tick();
    tick();
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_valid", {31'd0, warp_valid}, 32'd0);
    check("rst_cur", cur_block_id, 32'hFFFF_FFFF);
    rst = 1'b0;
    tick();

    // Block 0: two full warps.
    warp_q.push_back('{32'd0, 4'b1111, 16'd0});
    warp_q.push_back('{32'd4, 4'b1111, 16'd1});
    done_q.push_back(32'd0);
    start_block(32'd0);
    check("b0_setup_busy", {31'd0, busy}, 32'd1);
    check("b0_setup_valid", {31'd0, warp_valid}, 32'd0);
    check("b0_cur", cur_block_id, 32'd0);
    tick();
    do_warp();
    check("b0_second_issue", {31'd0, warp_valid}, 32'd1);
    check("b0_no_early_done", {31'd0, done}, 32'd0);
    do_warp();
    check("b0_done", {31'd0, done}, 32'd1);
    check("b0_busy_done", {31'd0, busy}, 32'd0);
    end_block();

    // Block 2: one partial warp.
    warp_q.push_back('{32'd16, 4'b0111, 16'd0});
    done_q.push_back(32'd2);
    start_block(32'd2);
    tick();
    do_warp();
    check("b2_done", {31'd0, done}, 32'd1);
    end_block();

    // Block 3: past the end of the kernel, no warps.
    done_q.push_back(32'd3);
    start_block(32'd3);
    check("b3_not_done_setup", {31'd0, done}, 32'd0);
    tick();
    check("b3_done", {31'd0, done}, 32'd1);
    check("b3_valid", {31'd0, warp_valid}, 32'd0);
    check("b3_bad", {31'd0, bad_block}, 32'd0);
    end_block();

    // Invalid block -1: straight to DONE.
    done_q.push_back(32'hFFFF_FFFF);
    start_block(32'hFFFF_FFFF);
    check("inv_done", {31'd0, done}, 32'd1);
    check("inv_bad", {31'd0, bad_block}, 32'd1);
    check("inv_busy", {31'd0, busy}, 32'd0);
    end_block();

    // Backpressure, spurious retire in ISSUE, retire with the handshake.
    warp_q.push_back('{32'd0, 4'b1111, 16'd0});
    warp_q.push_back('{32'd4, 4'b1111, 16'd1});
    done_q.push_back(32'd0);
    start_block(32'd0);
    check("bp_bad_cleared", {31'd0, bad_block}, 32'd0);
    tick();
    for (int i = 0; i < 5; i++) begin
      warp_retire = (i == 2);
      tick();
      warp_retire = 1'b0;
      check("bp_valid", {31'd0, warp_valid}, 32'd1);
      check("bp_tid", warp_base_tid, 32'd0);
      check("bp_mask", {28'd0, warp_mask}, 32'hF);
      check("bp_id", {16'd0, warp_id}, 32'd0);
    end
    warp_ready = 1'b1;
    warp_retire = 1'b1;
    tick();
    warp_ready = 1'b0;
    warp_retire = 1'b0;
    check("hs_retire_wait_valid", {31'd0, warp_valid}, 32'd0);
    tick();
    check("hs_retire_still_wait", {31'd0, warp_valid}, 32'd0);
    check("hs_retire_busy", {31'd0, busy}, 32'd1);
    warp_retire = 1'b1;
    tick();
    warp_retire = 1'b0;
    check("bp_next_valid", {31'd0, warp_valid}, 32'd1);
    check("bp_next_id", {16'd0, warp_id}, 32'd1);
    check("bp_next_tid", warp_base_tid, 32'd4);
    do_warp();
    check("bp_done", {31'd0, done}, 32'd1);
    end_block();

    // Reset in the middle of WAIT.
    warp_q.push_back('{32'd0, 4'b1111, 16'd0});
    start_block(32'd0);
    tick();
    warp_ready = 1'b1;
    tick();
    warp_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_cur", cur_block_id, 32'hFFFF_FFFF);
    check("mid_rst_tid", warp_base_tid, 32'd0);
    check("mid_rst_id", {16'd0, warp_id}, 32'd0);
    start = 1'b0;
    #2;
    rst = 1'b0;
    warp_retire = 1'b1;
    tick();
    warp_retire = 1'b0;
    tick();
    check("stale_retire_valid", {31'd0, warp_valid}, 32'd0);
    check("stale_retire_busy", {31'd0, busy}, 32'd0);
    check("stale_retire_done", {31'd0, done}, 32'd0);

    // Back-to-back blocks 0 and 1 with a one-cycle start gap.
    warp_q.push_back('{32'd0, 4'b1111, 16'd0});
    warp_q.push_back('{32'd4, 4'b1111, 16'd1});
    warp_q.push_back('{32'd8, 4'b1111, 16'd0});
    warp_q.push_back('{32'd12, 4'b1111, 16'd1});
    done_q.push_back(32'd0);
    done_q.push_back(32'd1);
    start_block(32'd0);
    tick();
    do_warp();
    do_warp();
    check("b2b_done0", {31'd0, done}, 32'd1);
    start = 1'b0;
    tick();
    check("b2b_gap_done", {31'd0, done}, 32'd0);
    start_block(32'd1);
    check("b2b_latch_done", {31'd0, done}, 32'd0);
    check("b2b_latch_cur", cur_block_id, 32'd1);
    check("b2b_latch_busy", {31'd0, busy}, 32'd1);
    tick();
    do_warp();
    do_warp();
    check("b2b_done1", {31'd0, done}, 32'd1);
    end_block();
    tick();

    check("warp_q_drained", warp_q.size(), 32'd0);
    check("done_q_drained", done_q.size(), 32'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
